// File: rtl/cpu_io_pkg.sv
// rtl/cpu_io_pkg.sv - shared types and helpers for the CPU output path
package cpu_io_pkg;

    typedef enum logic {A_IDLE, A_SER} accept_state_t;
    typedef enum logic [1:0] {D_IDLE, D_GAP, D_WAIT} drain_state_t;

    localparam int BYTES_PER_WORD = 4;

    // Requests longer than a word are clamped; a zero length stays a no-op.
    function automatic logic [2:0] eff_len(input logic [2:0] len);
        return (len > 3'(BYTES_PER_WORD)) ? 3'(BYTES_PER_WORD) : len;
    endfunction

endpackage

// File: rtl/print_output_scheduler_if.sv
// rtl/print_output_scheduler_if.sv - request and sender handshake bundle
interface print_output_scheduler_if;

    logic [1:0]       req_valid;
    logic [1:0][31:0] req_word;
    logic [1:0][2:0]  req_len;
    logic [1:0]       req_ready;
    logic [7:0]       tx_data;
    logic             tx_start;
    logic             tx_busy;

    modport master (
        output req_valid, req_word, req_len, tx_busy,
        input  req_ready, tx_data, tx_start
    );

    modport slave (
        input  req_valid, req_word, req_len, tx_busy,
        output req_ready, tx_data, tx_start
    );

endinterface

// File: rtl/byte_ring.sv
// rtl/byte_ring.sv - circular byte storage with head/tail pointers
module byte_ring #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic       CLK,
    input  logic       INITIALIZE_N,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data
);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] tail;

    // Pointers wrap naturally at DEPTH; fullness is tracked by the owner.
    always_ff @(posedge CLK or negedge INITIALIZE_N) begin
        if (!INITIALIZE_N) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (wr_en) tail <= tail + 1'b1;
            if (rd_en) head <= head + 1'b1;
        end
    end

    // Storage is never cleared; stale bytes are unreachable once pointers reset.
    always_ff @(posedge CLK) begin
        if (wr_en) mem[tail] <= wr_data;
    end

    assign rd_data = mem[head];

endmodule

// File: rtl/print_output_scheduler.sv
// rtl/print_output_scheduler.sv - two-port round-robin print arbiter feeding the UART sender
module print_output_scheduler
    import cpu_io_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    CLK,
    input  logic                    INITIALIZE_N,
    print_output_scheduler_if.slave bus,
    output logic [ADDR_W:0]         level,
    output logic                    idle
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    accept_state_t   a_state, a_next;
    drain_state_t    d_state, d_next;
    logic            last_grant, grant;
    logic [31:0]     word_q;
    logic [2:0]      len_q, k, g_len;
    logic [ADDR_W:0] used, avail, free;
    logic            fits, accept, wr_en, drain, last_byte;
    logic [1:0]      idx;
    logic [31:0]     shifted;
    logic [7:0]      wr_data, rd_data;

    // Round-robin grant, space check and the combinational ready.
    always_comb begin
        grant = 1'b0;
        if (bus.req_valid == 2'b11) grant = ~last_grant;
        else if (bus.req_valid[1])  grant = 1'b1;
        g_len  = eff_len(bus.req_len[grant]);
        free   = DEPTH_L - used;
        fits   = free >= (ADDR_W+1)'(g_len);
        accept = (a_state == A_IDLE) && fits && bus.req_valid[grant];
        bus.req_ready = 2'b00;
        if ((a_state == A_IDLE) && fits && INITIALIZE_N) bus.req_ready[grant] = 1'b1;
    end

    // Byte select: MSB-first within the effective length.
    always_comb begin
        wr_en     = (a_state == A_SER);
        last_byte = (k == len_q - 3'd1);
        idx       = 2'(len_q - 3'd1 - k);
        shifted   = word_q >> {idx, 3'b000};
        wr_data   = shifted[7:0];
    end

    // Accept FSM next state.
    always_comb begin
        a_next = a_state;
        case (a_state)
            A_IDLE:  if (accept && (g_len != 3'd0)) a_next = A_SER;
            A_SER:   if (last_byte) a_next = A_IDLE;
            default: a_next = A_IDLE;
        endcase
    end

    // Drain FSM next state; the gap cycle lets the sender raise busy.
    always_comb begin
        d_next = d_state;
        drain  = 1'b0;
        case (d_state)
            D_IDLE: begin
                if ((avail != '0) && !bus.tx_busy) begin
                    drain  = 1'b1;
                    d_next = D_GAP;
                end
            end
            D_GAP:   d_next = D_WAIT;
            D_WAIT:  if (!bus.tx_busy) d_next = D_IDLE;
            default: d_next = D_IDLE;
        endcase
    end

    // State registers for both FSMs.
    always_ff @(posedge CLK or negedge INITIALIZE_N) begin
        if (!INITIALIZE_N) begin
            a_state <= A_IDLE;
            d_state <= D_IDLE;
        end else begin
            a_state <= a_next;
            d_state <= d_next;
        end
    end

    // Latch the granted word and walk the byte index while serializing.
    always_ff @(posedge CLK or negedge INITIALIZE_N) begin
        if (!INITIALIZE_N) begin
            word_q     <= '0;
            len_q      <= '0;
            k          <= '0;
            last_grant <= 1'b1;
        end else if (accept) begin
            word_q     <= bus.req_word[grant];
            len_q      <= g_len;
            k          <= '0;
            last_grant <= grant;
        end else if (wr_en) begin
            k <= k + 3'd1;
        end
    end

    // Reserved and written counters; accept/write and drain may coincide.
    always_ff @(posedge CLK or negedge INITIALIZE_N) begin
        if (!INITIALIZE_N) begin
            used  <= '0;
            avail <= '0;
        end else begin
            used  <= used + (accept ? (ADDR_W+1)'(g_len) : '0) - (ADDR_W+1)'(drain);
            avail <= avail + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(drain);
        end
    end

    // Registered byte and start pulse toward the sender.
    always_ff @(posedge CLK or negedge INITIALIZE_N) begin
        if (!INITIALIZE_N) begin
            bus.tx_start <= 1'b0;
            bus.tx_data  <= '0;
        end else begin
            bus.tx_start <= drain;
            if (drain) bus.tx_data <= rd_data;
        end
    end

    byte_ring #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ring (
        .CLK          (CLK),
        .INITIALIZE_N (INITIALIZE_N),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (drain),
        .rd_data      (rd_data)
    );

    assign level = used;
    assign idle  = (a_state == A_IDLE) && (d_state == D_IDLE) && (used == '0);

endmodule

// File: tb/tb_print_output_scheduler.sv
// tb/tb_print_output_scheduler.sv - directed bench for print_output_scheduler
module tb_print_output_scheduler;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          CLK = 1'b0;
    logic          INITIALIZE_N;
    logic [AW:0]   level;
    logic          idle;

    print_output_scheduler_if bus();

    print_output_scheduler #(.DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .INITIALIZE_N (INITIALIZE_N),
        .bus          (bus),
        .level        (level),
        .idle         (idle)
    );

    always #5 CLK = ~CLK;

    int         checks = 0;
    int         errors = 0;
    int         cycle = 0;
    int         busy_cnt = 0;
    int         busy_len = 10;
    int         acc_cyc = 0;
    logic       hold_busy = 1'b0;
    logic [7:0] got[$];
    int         start_cyc[$];

    always @(posedge CLK) cycle <= cycle + 1;

    always @(negedge CLK) begin
        if (bus.tx_start) begin
            got.push_back(bus.tx_data);
            start_cyc.push_back(cycle);
            busy_cnt = busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
        end
    end

    assign bus.tx_busy = hold_busy || (busy_cnt != 0);

    function automatic int elen(input logic [2:0] l);
        return (l > 3'd4) ? 4 : int'(l);
    endfunction

    function automatic logic [7:0] get_byte(input int idx);
        if (idx < got.size()) return got[idx];
        return 8'hxx;
    endfunction

    task automatic send(input int p, input logic [31:0] w, input logic [2:0] l);
        int n;
        @(negedge CLK);
        bus.req_word[p]  = w;
        bus.req_len[p]   = l;
        bus.req_valid    = 2'b00;
        bus.req_valid[p] = 1'b1;
        n = 0;
        forever begin
            #1;
            if (bus.req_ready[p]) break;
            n++;
            if (n > 2000) begin
                checks++; errors++;
                $display("FAIL send_timeout port %0d ready %b required 1", p, bus.req_ready[p]);
                break;
            end
            @(negedge CLK);
        end
        acc_cyc = cycle + 1;
        @(negedge CLK);
        bus.req_valid = 2'b00;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge CLK); #1; n++;
        end while (!idle && n < 3000);
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle got %b required 1", name, idle);
        end
    endtask

    task automatic do_reset;
        INITIALIZE_N = 1'b0;
        repeat (2) @(negedge CLK);
        INITIALIZE_N = 1'b1;
    endtask

    task automatic test_reset;
        bus.req_valid = 2'b00;
        bus.req_word  = '0;
        bus.req_len   = '0;
        INITIALIZE_N  = 1'b1;
        #2 INITIALIZE_N = 1'b0;
        #1;
        checks++; if (level !== '0)         begin errors++; $display("FAIL reset_level got %0d required 0", level); end
        checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b required 0", bus.tx_start); end
        checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h required 00", bus.tx_data); end
        checks++; if (idle !== 1'b1)         begin errors++; $display("FAIL reset_idle got %b required 1", idle); end
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b required 00", bus.req_ready); end
        repeat (2) @(negedge CLK);
        INITIALIZE_N = 1'b1;
    endtask

    task automatic test_single_word;
        int base;
        logic [7:0] e [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        busy_len = 10;
        base = got.size();
        send(0, 32'h11223344, 3'd4);
        wait_idle("t1");
        checks++;
        if (got.size() - base != 4) begin errors++; $display("FAIL t1_pulses got %0d required 4", got.size() - base); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (get_byte(base + i) !== e[i]) begin errors++; $display("FAIL t1_byte%0d got %h required %h", i, get_byte(base + i), e[i]); end
        end
        checks++;
        if (got.size() <= base || start_cyc[base] - acc_cyc != 2) begin
            errors++;
            $display("FAIL t1_latency got %0d required 2", (got.size() > base) ? start_cyc[base] - acc_cyc : -1);
        end
        checks++; if (level !== '0) begin errors++; $display("FAIL t1_level got %0d required 0", level); end
    endtask

    task automatic test_len_variants;
        int base;
        logic [7:0] e [5] = '{8'hAB, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        busy_len = 3;
        base = got.size();
        send(1, 32'h000000AB, 3'd1);
        send(1, 32'h12345678, 3'd0);
        send(1, 32'hDEADBEEF, 3'd6);
        wait_idle("t2");
        checks++;
        if (got.size() - base != 5) begin errors++; $display("FAIL t2_count got %0d required 5", got.size() - base); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (get_byte(base + i) !== e[i]) begin errors++; $display("FAIL t2_byte%0d got %h required %h", i, get_byte(base + i), e[i]); end
        end
    endtask

    task automatic test_round_robin;
        int base, acc, n;
        int gr [4];
        int eg [4] = '{0, 1, 0, 1};
        logic [31:0] wd [2] = '{32'hA0A1A2A3, 32'hB0B1B2B3};
        logic [31:0] ww;
        do_reset();
        busy_len = 2;
        base = got.size();
        acc = 0; n = 0;
        @(negedge CLK);
        bus.req_word[0] = wd[0]; bus.req_len[0] = 3'd4;
        bus.req_word[1] = wd[1]; bus.req_len[1] = 3'd4;
        bus.req_valid = 2'b11;
        while (acc < 4 && n < 3000) begin
            #1;
            if (bus.req_ready[0])      begin gr[acc] = 0; acc++; end
            else if (bus.req_ready[1]) begin gr[acc] = 1; acc++; end
            @(negedge CLK);
            n++;
        end
        bus.req_valid = 2'b00;
        checks++;
        if (acc != 4) begin errors++; $display("FAIL t3_accepts got %0d required 4", acc); end
        for (int i = 0; i < acc; i++) begin
            checks++;
            if (gr[i] != eg[i]) begin errors++; $display("FAIL t3_grant%0d got %0d required %0d", i, gr[i], eg[i]); end
        end
        wait_idle("t3");
        checks++;
        if (got.size() - base != 16) begin errors++; $display("FAIL t3_count got %0d required 16", got.size() - base); end
        for (int i = 0; i < 16; i++) begin
            ww = wd[eg[i / 4]];
            checks++;
            if (get_byte(base + i) !== ww[8*(3 - i % 4) +: 8]) begin
                errors++;
                $display("FAIL t3_byte%0d got %h required %h", i, get_byte(base + i), ww[8*(3 - i % 4) +: 8]);
            end
        end
    endtask

    task automatic test_full_wrap;
        int base, n;
        base = got.size();
        hold_busy = 1'b1;
        busy_len  = 2;
        send(0, 32'h01020304, 3'd4);
        send(1, 32'h05060708, 3'd4);
        repeat (6) @(negedge CLK);
        #1;
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL t4_level_full got %0d required 8", level); end
        bus.req_word[0] = 32'h11111111; bus.req_len[0] = 3'd4; bus.req_valid = 2'b01;
        #1;
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL t4_full_len4 got %b required 00", bus.req_ready); end
        bus.req_word[0] = 32'h00000009; bus.req_len[0] = 3'd1;
        #1;
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL t4_full_len1 got %b required 00", bus.req_ready); end
        hold_busy = 1'b0;
        n = 0;
        do begin
            @(negedge CLK); #1; n++;
        end while (!bus.req_ready[0] && n < 200);
        checks++;
        if (bus.req_ready[0] !== 1'b1 || level !== 4'd7) begin
            errors++;
            $display("FAIL t4_accept_level got ready %b level %0d required ready 1 level 7", bus.req_ready[0], level);
        end
        @(negedge CLK);
        bus.req_valid = 2'b00;
        wait_idle("t4");
        checks++;
        if (got.size() - base != 9) begin errors++; $display("FAIL t4_count got %0d required 9", got.size() - base); end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (get_byte(base + i) !== 8'(i + 1)) begin errors++; $display("FAIL t4_byte%0d got %h required %h", i, get_byte(base + i), 8'(i + 1)); end
        end
    endtask

    task automatic test_simultaneous;
        int base, n, sent, sim, p, inc, e;
        bit pending, acc_last;
        logic [AW:0] prev_level;
        logic [31:0] w;
        logic [2:0] l;
        logic [7:0] expq[$];
        busy_len = 1;
        base = got.size();
        n = 0; sent = 0; sim = 0; p = 0; inc = 0;
        pending = 1'b0; acc_last = 1'b0;
        w = '0; l = '0;
        @(negedge CLK); #1;
        prev_level = level;
        while ((sent < 100 || pending || !idle) && n < 20000) begin
            @(negedge CLK); #1; n++;
            e = int'(prev_level) + inc - (bus.tx_start ? 1 : 0);
            checks++;
            if (level !== (AW+1)'(e)) begin errors++; $display("FAIL t5_level cycle %0d got %0d required %0d", n, level, e); end
            if (inc != 0 && bus.tx_start) sim++;
            prev_level = level;
            if (acc_last) begin
                pending = 1'b0;
                bus.req_valid = 2'b00;
            end
            if (!pending && sent < 100 && $urandom_range(0, 2) != 0) begin
                p = $urandom_range(0, 1);
                w = $urandom;
                l = 3'($urandom_range(0, 7));
                bus.req_word[p] = w;
                bus.req_len[p]  = l;
                bus.req_valid   = 2'b00;
                bus.req_valid[p] = 1'b1;
                pending = 1'b1;
                sent++;
            end
            #1;
            inc = 0;
            acc_last = 1'b0;
            if (pending && bus.req_ready[p]) begin
                acc_last = 1'b1;
                inc = elen(l);
                for (int i = elen(l) - 1; i >= 0; i--) expq.push_back(w[8*i +: 8]);
            end
        end
        bus.req_valid = 2'b00;
        checks++; if (n >= 20000) begin errors++; $display("FAIL t5_timeout got %0d cycles required < 20000", n); end
        checks++; if (sim == 0) begin errors++; $display("FAIL t5_simultaneous got %0d events required > 0", sim); end
        checks++;
        if (got.size() - base != expq.size()) begin errors++; $display("FAIL t5_count got %0d required %0d", got.size() - base, expq.size()); end
        for (int i = 0; i < expq.size(); i++) begin
            checks++;
            if (get_byte(base + i) !== expq[i]) begin errors++; $display("FAIL t5_byte%0d got %h required %h", i, get_byte(base + i), expq[i]); end
        end
    endtask

    task automatic test_reset_mid_ser;
        int base;
        busy_len = 10;
        @(negedge CLK);
        bus.req_word[0] = 32'hCAFEF00D; bus.req_len[0] = 3'd4; bus.req_valid = 2'b01;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL t6_pre_ready got %b required 01", bus.req_ready); end
        @(posedge CLK); #2;
        bus.req_valid = 2'b00;
        INITIALIZE_N  = 1'b0;
        #1;
        checks++; if (bus.tx_start !== 1'b0)  begin errors++; $display("FAIL t6_tx_start got %b required 0", bus.tx_start); end
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL t6_req_ready got %b required 00", bus.req_ready); end
        checks++; if (level !== '0)           begin errors++; $display("FAIL t6_level got %0d required 0", level); end
        checks++; if (idle !== 1'b1)          begin errors++; $display("FAIL t6_idle got %b required 1", idle); end
        repeat (2) @(negedge CLK);
        INITIALIZE_N = 1'b1;
        base = got.size();
        repeat (20) @(negedge CLK);
        checks++; if (got.size() != base) begin errors++; $display("FAIL t6_stale got %0d bytes required 0", got.size() - base); end
        send(1, 32'h0000005A, 3'd1);
        wait_idle("t6");
        checks++; if (got.size() - base != 1) begin errors++; $display("FAIL t6_count got %0d required 1", got.size() - base); end
        checks++; if (get_byte(base) !== 8'h5A) begin errors++; $display("FAIL t6_byte got %h required 5a", get_byte(base)); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_len_variants();
        test_round_robin();
        test_full_wrap();
        test_simultaneous();
        test_reset_mid_ser();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog time %0t", $time);
        $fatal(1);
    end

endmodule
